// File: rtl/adc_dual_spi_seq_if.sv
// Pin bundle toward a dual simultaneous-sampling SPI ADC plus the tagged A/B
// result stream handed to downstream capture logic.
interface adc_dual_spi_seq_if #(
    parameter int DATA_W = 12,
    parameter int CH_W   = 3
);
    logic              cs_n;
    logic              sck;
    logic [CH_W-1:0]   addr;
    logic              ad_range;
    logic              ad_diff;
    logic              outa;
    logic              outb;
    logic              smp_valid;
    logic [CH_W-1:0]   smp_ch;
    logic [DATA_W-1:0] smp_a;
    logic [DATA_W-1:0] smp_b;
    logic              smp_lead_err;

    modport master (
        output cs_n, sck, addr, ad_range, ad_diff,
        output smp_valid, smp_ch, smp_a, smp_b, smp_lead_err,
        input  outa, outb
    );

    modport slave (
        input  cs_n, sck, addr, ad_range, ad_diff,
        input  smp_valid, smp_ch, smp_a, smp_b, smp_lead_err,
        output outa, outb
    );
endinterface

// File: rtl/adc_dual_spi_seq.sv
// Scan controller and serial reader for a dual-line SPI ADC: walks the masked
// channel pairs, frames each conversion with CS/SCK and emits tagged results.
module adc_dual_spi_seq #(
    parameter int DATA_W     = 12,
    parameter int LEAD_ZEROS = 2,
    parameter int CLK_DIV    = 2,
    parameter int NUM_PAIRS  = 6,
    parameter int CH_W       = 3,
    parameter int QUIET_CYC  = 4
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 trig,
    input  logic [NUM_PAIRS-1:0] ch_mask,
    input  logic                 range_sel,
    input  logic                 diff_sel,
    output logic                 busy,
    output logic                 scan_done,
    adc_dual_spi_seq_if.master   bus
);
    localparam int FRAME_SCK = LEAD_ZEROS + DATA_W;
    localparam int DIV_W     = $clog2(CLK_DIV + 1);
    localparam int BIT_W     = $clog2(FRAME_SCK + 1);
    localparam int QUIET_W   = $clog2(QUIET_CYC + 1);
    localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST   = BIT_W'(FRAME_SCK);
    localparam logic [QUIET_W-1:0]   QUIET_LAST = QUIET_W'(QUIET_CYC - 1);
    localparam logic [FRAME_SCK-1:0] LEAD_MASK  = ~({FRAME_SCK{1'b1}} >> LEAD_ZEROS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FRAME = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // {found, index} of the lowest set mask bit whose index is >= floor_idx
    function automatic logic [CH_W:0] pick_pair(input logic [NUM_PAIRS-1:0] mask,
                                                input logic [CH_W:0]        floor_idx);
        logic [CH_W:0] res;
        res = '0;
        for (int i = NUM_PAIRS - 1; i >= 0; i--) begin
            if (mask[i] && ((CH_W+1)'(i) >= floor_idx)) begin
                res = {1'b1, CH_W'(i)};
            end
        end
        return res;
    endfunction

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [QUIET_W-1:0]     quiet_q, quiet_d;
    logic [NUM_PAIRS-1:0]   scan_mask_q, scan_mask_d;
    logic [FRAME_SCK-1:0]   sha_q, sha_d, shb_q, shb_d;
    logic                   cs_n_q, cs_n_d, sck_q, sck_d;
    logic [CH_W-1:0]        addr_q, addr_d;
    logic                   range_q, diff_q;
    logic                   busy_q, busy_d;
    logic                   smp_valid_q, smp_valid_d;
    logic [CH_W-1:0]        smp_ch_q, smp_ch_d;
    logic [DATA_W-1:0]      smp_a_q, smp_a_d, smp_b_q, smp_b_d;
    logic                   lead_err_q, lead_err_d;
    logic                   scan_done_q, scan_done_d;
    logic [CH_W:0]          first_pick_s, next_pick_s;

    // Next-state and output-register logic of the scan FSM
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        quiet_d     = quiet_q;
        scan_mask_d = scan_mask_q;
        sha_d       = sha_q;
        shb_d       = shb_q;
        cs_n_d      = cs_n_q;
        sck_d       = sck_q;
        addr_d      = addr_q;
        smp_valid_d = 1'b0;
        smp_ch_d    = smp_ch_q;
        smp_a_d     = smp_a_q;
        smp_b_d     = smp_b_q;
        lead_err_d  = lead_err_q;
        scan_done_d = 1'b0;
        first_pick_s = pick_pair(ch_mask, '0);
        next_pick_s  = pick_pair(scan_mask_q, {1'b0, addr_q} + (CH_W+1)'(1));

        case (state_q)
            ST_IDLE: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b1;
                if ((enable || trig) && first_pick_s[CH_W]) begin
                    scan_mask_d = ch_mask;
                    addr_d      = first_pick_s[CH_W-1:0];
                    quiet_d     = '0;
                    state_d     = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (quiet_q == QUIET_LAST) begin
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_FRAME;
                end else begin
                    quiet_d = quiet_q + QUIET_W'(1);
                end
            end
            ST_FRAME: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sck_q) begin
                        // rising SCK edge: ADC data has been stable for a half period
                        sck_d = 1'b1;
                        sha_d = {sha_q[FRAME_SCK-2:0], bus.outa};
                        shb_d = {shb_q[FRAME_SCK-2:0], bus.outb};
                        bit_d = bit_q + BIT_W'(1);
                    end else if (bit_q == BIT_LAST) begin
                        cs_n_d      = 1'b1;
                        smp_valid_d = 1'b1;
                        smp_ch_d    = addr_q;
                        smp_a_d     = sha_q[DATA_W-1:0];
                        smp_b_d     = shb_q[DATA_W-1:0];
                        lead_err_d  = (|(sha_q & LEAD_MASK)) | (|(shb_q & LEAD_MASK));
                        scan_done_d = ~next_pick_s[CH_W];
                        state_d     = ST_DONE;
                    end else begin
                        sck_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DONE: begin
                quiet_d = '0;
                if (next_pick_s[CH_W]) begin
                    addr_d  = next_pick_s[CH_W-1:0];
                    state_d = ST_SETUP;
                end else if (enable && first_pick_s[CH_W]) begin
                    scan_mask_d = ch_mask;
                    addr_d      = first_pick_s[CH_W-1:0];
                    state_d     = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                sck_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset forces the bus idle mid-frame
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            quiet_q     <= '0;
            scan_mask_q <= '0;
            sha_q       <= '0;
            shb_q       <= '0;
            cs_n_q      <= 1'b1;
            sck_q       <= 1'b1;
            addr_q      <= '0;
            range_q     <= 1'b0;
            diff_q      <= 1'b0;
            busy_q      <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_ch_q    <= '0;
            smp_a_q     <= '0;
            smp_b_q     <= '0;
            lead_err_q  <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            quiet_q     <= quiet_d;
            scan_mask_q <= scan_mask_d;
            sha_q       <= sha_d;
            shb_q       <= shb_d;
            cs_n_q      <= cs_n_d;
            sck_q       <= sck_d;
            addr_q      <= addr_d;
            range_q     <= range_sel;
            diff_q      <= diff_sel;
            busy_q      <= busy_d;
            smp_valid_q <= smp_valid_d;
            smp_ch_q    <= smp_ch_d;
            smp_a_q     <= smp_a_d;
            smp_b_q     <= smp_b_d;
            lead_err_q  <= lead_err_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign bus.cs_n         = cs_n_q;
    assign bus.sck          = sck_q;
    assign bus.addr         = addr_q;
    assign bus.ad_range     = range_q;
    assign bus.ad_diff      = diff_q;
    assign bus.smp_valid    = smp_valid_q;
    assign bus.smp_ch       = smp_ch_q;
    assign bus.smp_a        = smp_a_q;
    assign bus.smp_b        = smp_b_q;
    assign bus.smp_lead_err = lead_err_q;
    assign busy             = busy_q;
    assign scan_done        = scan_done_q;
endmodule

// File: tb/tb_adc_dual_spi_seq.sv
// Scoreboard bench: stimulus pushes expected results from a table-driven ADC
// model; negedge monitors drive the serial lines and check frames and strobes.
module tb_adc_dual_spi_seq;
    localparam int DW = 12, LZ = 2, CD = 2, NP = 6, CW = 3, QC = 4;
    localparam int FS = DW + LZ;
    localparam int FRAME_LOW = 2 * CD * FS + CD;
    localparam int PERIOD = FRAME_LOW + 1 + QC;
    localparam int DW2 = 14, CD2 = 3;
    localparam int FS2 = DW2;
    localparam int FRAME_LOW2 = 2 * CD2 * FS2 + CD2;

    typedef struct {
        logic [CW-1:0] ch;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          lead;
        logic          last;
    } exp_t;

    typedef struct {
        logic [CW-1:0]  ch;
        logic [DW2-1:0] a;
        logic [DW2-1:0] b;
        logic           last;
    } exp2_t;

    logic sys_clk = 1'b0, rst_n = 1'b0;
    logic enable = 1'b0, trig = 1'b0, enable2 = 1'b0, trig2 = 1'b0;
    logic [NP-1:0] ch_mask = '0, ch_mask2 = '0;
    logic range_sel = 1'b0, diff_sel = 1'b0;
    logic busy, scan_done, busy2, scan_done2;

    int checks = 0, errors = 0, cyc = 0;

    logic [DW-1:0]  tab_a [NP], tab_b [NP];
    logic [LZ-1:0]  tab_la [NP], tab_lb [NP];
    logic [DW2-1:0] tab2_a [NP], tab2_b [NP];
    exp_t  sb0[$];
    exp2_t sb2[$];
    logic [CW-1:0] exp_addr0[$], exp_addr2[$];

    int  falls0 = 0, last_fall0 = -1, fall_cyc0 = 0, sck_falls0 = 0, start_cyc = 0;
    bit  first_pending = 1'b0, in_frame0 = 1'b0, prev_cs0 = 1'b1, prev_sck0 = 1'b1;
    logic [FS-1:0] word_a0, word_b0;
    logic [DW-1:0] last_a0 = '0;
    int  fall_cyc2 = 0, sck_falls2 = 0, last_sck2 = 0;
    bit  in_frame2 = 1'b0, prev_cs2 = 1'b1, prev_sck2 = 1'b1;
    logic [FS2-1:0] word_a2, word_b2;

    adc_dual_spi_seq_if #(.DATA_W(DW), .CH_W(CW)) bus ();
    adc_dual_spi_seq_if #(.DATA_W(DW2), .CH_W(CW)) bus2 ();

    adc_dual_spi_seq #(.DATA_W(DW), .LEAD_ZEROS(LZ), .CLK_DIV(CD), .NUM_PAIRS(NP),
                       .CH_W(CW), .QUIET_CYC(QC)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .trig(trig), .ch_mask(ch_mask),
        .range_sel(range_sel), .diff_sel(diff_sel), .busy(busy), .scan_done(scan_done),
        .bus(bus.master)
    );

    adc_dual_spi_seq #(.DATA_W(DW2), .LEAD_ZEROS(0), .CLK_DIV(CD2), .NUM_PAIRS(NP),
                       .CH_W(CW), .QUIET_CYC(QC)) dut2 (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable2), .trig(trig2), .ch_mask(ch_mask2),
        .range_sel(range_sel), .diff_sel(diff_sel), .busy(busy2), .scan_done(scan_done2),
        .bus(bus2.master)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC model and scoreboard monitor for the default-parameter instance
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            in_frame0 = 1'b0;
            prev_cs0  = 1'b1;
            prev_sck0 = 1'b1;
            last_fall0 = -1;
        end else begin
            if (prev_cs0 && !bus.cs_n) begin
                falls0++;
                if (exp_addr0.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    chk("addr", 32'(bus.addr), 32'(exp_addr0.pop_front()));
                end
                if (first_pending) begin
                    chk("start_latency", cyc - start_cyc, 1 + QC);
                    first_pending = 1'b0;
                end else if (last_fall0 >= 0) begin
                    chk("frame_period", cyc - last_fall0, PERIOD);
                end
                last_fall0 = cyc;
                fall_cyc0  = cyc;
                sck_falls0 = 0;
                in_frame0  = 1'b1;
                word_a0 = {tab_la[bus.addr], tab_a[bus.addr]};
                word_b0 = {tab_lb[bus.addr], tab_b[bus.addr]};
                bus.outa = 1'($urandom);
                bus.outb = 1'($urandom);
            end
            if (in_frame0 && prev_sck0 && !bus.sck) begin
                bus.outa = word_a0[FS-1-sck_falls0];
                bus.outb = word_b0[FS-1-sck_falls0];
                sck_falls0++;
            end
            if (in_frame0 && !prev_cs0 && bus.cs_n) begin
                chk("sck_falls", sck_falls0, FS);
                chk("cs_low_cycles", cyc - fall_cyc0, FRAME_LOW);
                chk("sck_high_end", 32'(bus.sck), 32'd1);
                in_frame0 = 1'b0;
            end
            if (bus.smp_valid) begin
                if (sb0.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb0.pop_front();
                    chk("smp_ch", 32'(bus.smp_ch), 32'(e.ch));
                    chk("smp_a", 32'(bus.smp_a), 32'(e.a));
                    chk("smp_b", 32'(bus.smp_b), 32'(e.b));
                    chk("smp_lead_err", 32'(bus.smp_lead_err), 32'(e.lead));
                    chk("scan_done", 32'(scan_done), 32'(e.last));
                    last_a0 = e.a;
                    if (e.last) last_fall0 = -1;
                end
            end else if (scan_done) begin
                chk("scan_done_without_strobe", 32'd1, 32'd0);
            end
            prev_cs0  = bus.cs_n;
            prev_sck0 = bus.sck;
        end
    end

    // ADC model and scoreboard monitor for the wide, slow-SCK instance
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            in_frame2 = 1'b0;
            prev_cs2  = 1'b1;
            prev_sck2 = 1'b1;
        end else begin
            if (prev_cs2 && !bus2.cs_n) begin
                if (exp_addr2.size() == 0) chk("w_unexpected_frame", 32'd1, 32'd0);
                else chk("w_addr", 32'(bus2.addr), 32'(exp_addr2.pop_front()));
                fall_cyc2  = cyc;
                sck_falls2 = 0;
                in_frame2  = 1'b1;
                word_a2 = tab2_a[bus2.addr];
                word_b2 = tab2_b[bus2.addr];
            end
            if (in_frame2 && prev_sck2 && !bus2.sck) begin
                if (sck_falls2 > 0) chk("w_sck_period", cyc - last_sck2, 2 * CD2);
                last_sck2 = cyc;
                bus2.outa = word_a2[FS2-1-sck_falls2];
                bus2.outb = word_b2[FS2-1-sck_falls2];
                sck_falls2++;
            end
            if (in_frame2 && !prev_cs2 && bus2.cs_n) begin
                chk("w_sck_falls", sck_falls2, FS2);
                chk("w_cs_low_cycles", cyc - fall_cyc2, FRAME_LOW2);
                in_frame2 = 1'b0;
            end
            if (bus2.smp_valid) begin
                if (sb2.size() == 0) begin
                    chk("w_unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    exp2_t e;
                    e = sb2.pop_front();
                    chk("w_smp_ch", 32'(bus2.smp_ch), 32'(e.ch));
                    chk("w_smp_a", 32'(bus2.smp_a), 32'(e.a));
                    chk("w_smp_b", 32'(bus2.smp_b), 32'(e.b));
                    chk("w_lead_err", 32'(bus2.smp_lead_err), 32'd0);
                    chk("w_scan_done", 32'(scan_done2), 32'(e.last));
                end
            end
            prev_cs2  = bus2.cs_n;
            prev_sck2 = bus2.sck;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic rand_tables();
        for (int i = 0; i < NP; i++) begin
            tab_a[i]  = DW'($urandom);
            tab_b[i]  = DW'($urandom);
            tab_la[i] = ($urandom_range(0, 3) == 0) ? LZ'($urandom) : '0;
            tab_lb[i] = ($urandom_range(0, 3) == 0) ? LZ'($urandom) : '0;
            tab2_a[i] = DW2'($urandom);
            tab2_b[i] = DW2'($urandom);
        end
    endtask

    // Reference: pairs come out in ascending index order, the highest one closes the scan
    task automatic push_scan(input logic [NP-1:0] m);
        int hi = -1;
        for (int i = 0; i < NP; i++) if (m[i]) hi = i;
        for (int i = 0; i < NP; i++) begin
            if (m[i]) begin
                exp_t e;
                e.ch   = CW'(i);
                e.a    = tab_a[i];
                e.b    = tab_b[i];
                e.lead = (tab_la[i] != 0) || (tab_lb[i] != 0);
                e.last = (i == hi);
                sb0.push_back(e);
                exp_addr0.push_back(CW'(i));
            end
        end
    endtask

    task automatic pulse_trig(input bit timed);
        if (timed) begin
            first_pending = 1'b1;
            start_cyc = cyc;
        end
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        repeat (3) @(negedge sys_clk);
        while ((busy || sb0.size() != 0) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk("scan_finished", 32'(n < budget), 32'd1);
        chk("busy_low", 32'(busy), 32'd0);
        chk("smp_a_hold", 32'(bus.smp_a), 32'(last_a0));
    endtask

    task automatic wait_falls(input int target, input int budget);
        int n = 0;
        while (falls0 < target && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk("frame_reached", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int n;
        exp2_t e2;
        logic [NP-1:0] m;
        repeat (3) tick();
        chk("rst_cs_n", 32'(bus.cs_n), 32'd1);
        chk("rst_sck", 32'(bus.sck), 32'd1);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_ad_range", 32'(bus.ad_range), 32'd0);
        chk("rst_ad_diff", 32'(bus.ad_diff), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_smp_valid", 32'(bus.smp_valid), 32'd0);
        chk("rst_smp_ch", 32'(bus.smp_ch), 32'd0);
        chk("rst_smp_a", 32'(bus.smp_a), 32'd0);
        chk("rst_smp_b", 32'(bus.smp_b), 32'd0);
        chk("rst_lead_err", 32'(bus.smp_lead_err), 32'd0);
        chk("rst_scan_done", 32'(scan_done), 32'd0);
        rst_n = 1'b1;
        repeat (1000) tick();
        chk("idle_no_frames", falls0, 0);

        for (int i = 0; i < 4; i++) begin
            range_sel = 1'($urandom);
            diff_sel  = 1'($urandom);
            tick();
            chk("ad_range", 32'(bus.ad_range), 32'(range_sel));
            chk("ad_diff", 32'(bus.ad_diff), 32'(diff_sel));
        end

        rand_tables();
        tab_a[0] = 12'hA5C; tab_b[0] = 12'h3F1; tab_la[0] = 2'b00; tab_lb[0] = 2'b00;
        tab_a[2] = 12'h001; tab_b[2] = 12'hFFF; tab_la[2] = 2'b00; tab_lb[2] = 2'b00;
        ch_mask = 6'b000101;
        push_scan(ch_mask);
        pulse_trig(1'b1);
        wait_idle(2000);

        rand_tables();
        for (int i = 0; i < NP; i++) begin
            tab_la[i] = 2'b00;
            tab_lb[i] = 2'b00;
        end
        tab_lb[1] = 2'b01;
        ch_mask = 6'b000111;
        push_scan(ch_mask);
        pulse_trig(1'b1);
        wait_idle(2000);

        for (int k = 0; k < 6; k++) begin
            rand_tables();
            ch_mask = NP'($urandom_range(1, (1 << NP) - 1));
            push_scan(ch_mask);
            pulse_trig(1'b1);
            wait_idle(3000);
        end

        rand_tables();
        ch_mask = 6'b111111;
        push_scan(ch_mask);
        n = falls0;
        first_pending = 1'b1;
        start_cyc = cyc;
        enable = 1'b1;
        wait_falls(n + 4, 2000);
        tick();
        enable = 1'b0;
        repeat (5) tick();
        pulse_trig(1'b0);
        wait_idle(3000);
        repeat (200) tick();

        rand_tables();
        ch_mask = 6'b100001;
        push_scan(ch_mask);
        push_scan(ch_mask);
        n = falls0;
        first_pending = 1'b1;
        start_cyc = cyc;
        enable = 1'b1;
        wait_falls(n + 3, 2000);
        tick();
        enable = 1'b0;
        wait_idle(3000);

        ch_mask = '0;
        n = falls0;
        enable = 1'b1;
        pulse_trig(1'b0);
        repeat (50) tick();
        chk("mask0_busy", 32'(busy), 32'd0);
        chk("mask0_no_frame", falls0, n);
        enable = 1'b0;

        rand_tables();
        ch_mask = 6'b000001;
        exp_addr0.push_back(3'd0);
        pulse_trig(1'b1);
        n = 0;
        while (!(in_frame0 && sck_falls0 >= 7) && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        chk("reached_sck7", 32'(n < 500), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 32'(bus.cs_n), 32'd1);
        chk("abort_sck", 32'(bus.sck), 32'd1);
        chk("abort_valid", 32'(bus.smp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (200) tick();
        chk("abort_no_frame", 32'(exp_addr0.size()), 32'd0);

        rand_tables();
        ch_mask2 = 6'b010010;
        for (int i = 1; i < NP; i += 3) begin
            e2.ch = CW'(i);
            e2.a = tab2_a[i];
            e2.b = tab2_b[i];
            e2.last = (i == 4);
            sb2.push_back(e2);
            exp_addr2.push_back(CW'(i));
        end
        trig2 = 1'b1;
        tick();
        trig2 = 1'b0;
        n = 0;
        repeat (3) tick();
        while ((busy2 || sb2.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        chk("w_scan_finished", 32'(n < 3000), 32'd1);

        repeat (10) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
